mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 22 ++
 rtl/mem_wb_stage_data_mem.sv | 29 ++
 rtl/mem_wb_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the execute/memory/writeback boundary: operation
// codes, FSM state encodings and default datapath widths.
package mem_wb_stage_pkg;

  localparam int MW_DATA_W = 64;
  localparam int MW_ADDR_W = 8;
  localparam int MW_REG_W  = 4;
  localparam int MW_CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Single-port-per-direction data memory: synchronous write, one-cycle
// registered read. Contents are never reset.
module data_mem
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = MW_DATA_W,
  parameter int ADDR_W = MW_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: ALU results retire next cycle, loads take one extra
// cycle through the registered data memory, stores write in place.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = MW_DATA_W,
  parameter int ADDR_W = MW_ADDR_W,
  parameter int REG_W  = MW_REG_W,
  parameter int CNT_W  = MW_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        control_signals_in,
  input  logic [DATA_W-1:0] value_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [REG_W-1:0]  reg_to_be_written_in,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retired_count
);

  state_e            state;
  state_e            state_nxt;
  op_e               op_p0;
  logic              accept_p0;
  logic              alu_p0;
  logic              load_p0;
  logic              store_p0;
  logic              vld_p1;
  logic [REG_W-1:0]  load_reg_p1;
  logic [DATA_W-1:0] rdata_p1;

  // Stage p0: accept decision. Gated on rst_n so nothing (including a store)
  // takes effect on a reset edge; ready comes from state only to avoid a loop.
  assign op_p0     = op_e'(control_signals_in);
  assign accept_p0 = rst_n && in_valid && (state == ST_IDLE);
  assign alu_p0    = accept_p0 && (op_p0 == OP_ALU);
  assign load_p0   = accept_p0 && (op_p0 == OP_LOAD);
  assign store_p0  = accept_p0 && (op_p0 == OP_STORE);

  data_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (store_p0),
    .waddr (address_in),
    .wdata (value_in),
    .re    (load_p0),
    .raddr (address_in),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (load_p0) begin
          state_nxt = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stage p1: load in flight; read word is in rdata_p1, destination captured here.
  assign vld_p1 = (state == ST_LOAD_WAIT);

  always_ff @(posedge clk) begin
    if (load_p0) begin
      load_reg_p1 <= reg_to_be_written_in;
    end
  end

  // Stage p2: register-file write port. Only one source can be active per
  // cycle because no op is accepted while a load is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= 1'b0;
      if (alu_p0) begin
        wb_en   <= 1'b1;
        wb_reg  <= reg_to_be_written_in;
        wb_data <= value_in;
      end else if (vld_p1) begin
        wb_en   <= 1'b1;
        wb_reg  <= load_reg_p1;
        wb_data <= rdata_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (accept_p0) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule
